simd_result_drain: RTL and testbench
====================================

SIMD_RESULT_DRAIN -- requirements
Module: simd_result_drain

Interface
Parameters:
REQ-001 SHALL provide parameter BW, default 8; array operand width, result word width 2*BW.
REQ-002 SHALL provide parameter LAT, default 3; cycles from operand issue to valid adder-tree outputs.
REQ-003 SHALL provide parameter DEPTH, default 2; result frames bufferable.

Ports:
REQ-004 SHALL have clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have issue_valid  in  1  operands presented to array this cycle.
REQ-007 SHALL have lvl_sel  in  2  level to drain, sampled with issue_valid: 0=L1 (16 words), 1=L2 (4), 2=L3 (1), 3=all (21).
REQ-008 SHALL have issue_ready  out  1  issue will be accepted this cycle.
REQ-009 SHALL have iL1  in  16 x 2*BW  adder-tree level-1 sums.
REQ-010 SHALL have iL2  in  4 x 2*BW  level-2 sums.
REQ-011 SHALL have iL3  in  2*BW  level-3 sum.
REQ-012 SHALL have o_valid  out  1, o_ready  in  1, o_data  out  2*BW, o_idx  out  5 (word index within frame), o_last  out  1.
REQ-013 SHALL have err_drop  out  1  sticky: an issue was dropped.

Function
REQ-014 Accepted issue = issue_valid && issue_ready; SHALL enter LAT-stage delay line carrying {valid, lvl_sel}.
REQ-015 When a valid token leaves the delay line (issue cycle c), SHALL sample iL1/iL2/iL3 in cycle c+LAT and write frame {words, lvl_sel} into FIFO at that edge.
REQ-016 issue_ready SHALL be 1 iff (tokens in flight + FIFO occupancy, counting the frame in SEND) < DEPTH; capture into a full FIFO is thereby impossible.
REQ-017 issue_valid while issue_ready=0 SHALL be ignored and SHALL set err_drop, held until rst.
REQ-018 Serializer FSM states IDLE, SEND: IDLE with FIFO non-empty -> load head, SEND, idx=0; SEND on handshake with o_last -> pop, IDLE; otherwise stay.
REQ-019 Word order SHALL be: lvl0 L1[0..15]; lvl1 L2[0..3]; lvl2 L3; lvl3 L1[0..15], L2[0..3], L3 (idx 0..20).
REQ-020 o_valid SHALL be 1 exactly in SEND; o_data/o_idx/o_last SHALL hold stable while o_valid && !o_ready.
REQ-021 idx SHALL advance by 1 per handshake; o_last=1 on final word (idx 15/3/0/20 for lvl 0/1/2/3).
REQ-022 First o_valid SHALL occur in cycle c+LAT+2 when FSM IDLE and FIFO empty; exactly one o_valid=0 cycle SHALL separate consecutive frames.
REQ-023 Capture and pop in same cycle SHALL both take effect; credit count SHALL reflect both.
REQ-024 o_data SHALL be 0 whenever o_valid=0.

Reset
REQ-025 rst=1 at an edge SHALL clear delay line, FIFO, credit count, FSM (IDLE), idx, err_drop; next cycle o_valid=0, o_data=0, o_idx=0, o_last=0, issue_ready=1.
REQ-026 rst mid-frame SHALL abandon frame and all in-flight tokens without emitting further words.

Verification
REQ-027 Reset: rst=1 two cycles -> o_valid=0, issue_ready=1, err_drop=0.
REQ-028 Single L3: issue lvl=2 cycle 0, iL3=16'h1234 in cycle 3, o_ready=1 -> o_valid only cycle 5, o_data=16'h1234, o_idx=0, o_last=1.
REQ-029 Full frame: lvl=3, iL1[k]=k, iL2[k]=16'h100+k, iL3=16'h200, o_ready=1 -> 21 consecutive beats, idx 0..20, data 0..15, 16'h100..16'h103, 16'h200, o_last only idx 20.
REQ-030 Backpressure: lvl=0 frame, o_ready=0 for 5 cycles at idx 7 -> o_data=7, o_idx=7 held; resumes 8..15, no loss or duplication.
REQ-031 Credit: DEPTH=2, o_ready=0, issue_valid cycles 0,1,2 -> issue_ready=0 in cycle 2, third dropped, err_drop=1; o_ready=1 later -> exactly two frames, one idle cycle between.
REQ-032 Reset mid-frame: rst at idx 10 of lvl=3 frame with second frame queued -> o_valid=0 after reset, no further beats, issue_ready=1.

Source files
------------

// File: rtl/simd_result_drain.sv
// Result drain for a SIMD adder tree: tracks issued operand tokens through the
// array latency, captures L1/L2/L3 sums into a frame FIFO and serializes words.
module simd_result_drain #(
  parameter int BW    = 8,
  parameter int LAT   = 3,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [1:0]                 lvl_sel,
  output logic                       issue_ready,
  input  logic [15:0][2*BW-1:0]      iL1,
  input  logic [3:0][2*BW-1:0]       iL2,
  input  logic [2*BW-1:0]            iL3,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [2*BW-1:0]            o_data,
  output logic [4:0]                 o_idx,
  output logic                       o_last,
  output logic                       err_drop,
  output logic                       dbg_state
);

  // Output handshake: a word transfers on a rising edge where o_valid && o_ready;
  // while o_valid && !o_ready the word, index and last flag hold stable.

  localparam int W  = 2 * BW;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [15:0][W-1:0] l1;
    logic [3:0][W-1:0]  l2;
    logic [W-1:0]       l3;
    logic [1:0]         lvl;
  } frame_t;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [4:0]           idx_q, idx_d;
  logic [LAT-1:0]       dv_q, dv_d;
  logic [LAT-1:0][1:0]  dl_q, dl_d;
  frame_t               mem_q [DEPTH];
  frame_t               mem_d [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        cred_q, cred_d;
  logic                 err_q, err_d;

  logic                 accept, capture, pop, fifo_empty;
  frame_t               head;
  logic [W-1:0]         word;
  logic [4:0]           last_idx;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept     = issue_valid && issue_ready;
  assign capture    = dv_q[LAT-1];
  assign fifo_empty = (cnt_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign pop        = (state_q == SEND) && o_ready && o_last;

  // Credits cover tokens in flight plus stored frames; capture only moves a
  // credit from the delay line into the FIFO, so it never changes the count.
  assign issue_ready = (cred_q < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      dv_q     <= '0;
      dl_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      cred_q   <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dv_q     <= dv_d;
      dl_q     <= dl_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      cred_q   <= cred_d;
      err_q    <= err_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    dv_d    = '0;
    dl_d    = '0;
    dv_d[0] = accept;
    dl_d[0] = lvl_sel;
    for (int i = 1; i < LAT; i++) begin
      dv_d[i] = dv_q[i-1];
      dl_d[i] = dl_q[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (capture) begin
      mem_d[wr_ptr_q] = '{l1: iL1, l2: iL2, l3: iL3, lvl: dl_q[LAT-1]};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d  = cnt_q + CW'(capture) - CW'(pop);
    cred_d = cred_q + CW'(accept) - CW'(pop);
    err_d  = err_q | (issue_valid & ~issue_ready);
  end

  // Next-state logic for the serializer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (!fifo_empty) state_d = SEND;
      end
      SEND: begin
        if (o_ready) begin
          if (o_last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word selection; L2 words in the combined frame sit at idx 16..19, so the
  // low two index bits address them directly.
  always_comb begin
    word     = '0;
    last_idx = 5'd0;
    case (head.lvl)
      2'd0: begin
        word     = head.l1[idx_q[3:0]];
        last_idx = 5'd15;
      end
      2'd1: begin
        word     = head.l2[idx_q[1:0]];
        last_idx = 5'd3;
      end
      2'd2: begin
        word     = head.l3;
        last_idx = 5'd0;
      end
      default: begin
        if (idx_q < 5'd16)      word = head.l1[idx_q[3:0]];
        else if (idx_q < 5'd20) word = head.l2[idx_q[1:0]];
        else                    word = head.l3;
        last_idx = 5'd20;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    o_valid   = (state_q == SEND);
    o_data    = o_valid ? word : '0;
    o_idx     = idx_q;
    o_last    = o_valid && (idx_q == last_idx);
    err_drop  = err_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_simd_result_drain.sv
// Directed bench for simd_result_drain with a scoreboard of expected output beats.
module tb_simd_result_drain;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [1:0]        lvl_sel;
  logic              issue_ready;
  logic [15:0][15:0] il1;
  logic [3:0][15:0]  il2;
  logic [15:0]       il3;
  logic              o_valid;
  logic              o_ready;
  logic [15:0]       o_data;
  logic [4:0]        o_idx;
  logic              o_last;
  logic              err_drop;
  logic              dbg_state;

  int total = 0;
  int bad   = 0;
  logic [21:0] exp_q[$];

  simd_result_drain #(.BW(8), .LAT(3), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .lvl_sel(lvl_sel),
    .issue_ready(issue_ready), .iL1(il1), .iL2(il2), .iL3(il3),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_idx(o_idx),
    .o_last(o_last), .err_drop(err_drop), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic last, input logic [15:0] data);
    exp_q.push_back({5'(idx), last, data});
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (o_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk(tag, 32'(o_valid), 32'(1));
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'(0));
  endtask

  // Scoreboard: every handshake pops and compares {idx, last, data}.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (o_valid === 1'b1 && o_ready === 1'b1) begin
        logic [21:0] e;
        chk("sb_beat_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_beat", 32'({o_idx, o_last, o_data}), 32'(e));
        end
      end else if (o_valid === 1'b0) begin
        chk("data_zero_idle", 32'(o_data), 32'(0));
      end
    end
  end

  initial begin
    int cnt;
    rst = 1'b1; issue_valid = 1'b0; lvl_sel = 2'd0; o_ready = 1'b1;
    for (int k = 0; k < 16; k++) il1[k] = 16'(k);
    for (int k = 0; k < 4; k++) il2[k] = 16'h100 + 16'(k);
    il3 = 16'hbeef;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_o_valid", 32'(o_valid), 32'(0));
    chk("rst_issue_ready", 32'(issue_ready), 32'(1));
    chk("rst_err_drop", 32'(err_drop), 32'(0));
    chk("rst_o_idx", 32'(o_idx), 32'(0));
    chk("rst_o_last", 32'(o_last), 32'(0));
    step();

    // Single L3 word: iL3 valid only in cycle 3, beat only in cycle 5
    issue_valid = 1'b1; lvl_sel = 2'd2;
    chk("l3_issue_ready", 32'(issue_ready), 32'(1));
    push(0, 1'b1, 16'h1234);
    for (int c = 1; c <= 8; c++) begin
      step();
      issue_valid = 1'b0;
      il3 = (c == 3) ? 16'h1234 : 16'hbeef;
      chk($sformatf("l3_valid_cyc%0d", c), 32'(o_valid), 32'(c == 5));
    end
    chk("l3_drained", 32'(exp_q.size()), 32'(0));

    // Full lvl3 frame: 21 consecutive beats
    il3 = 16'h200;
    issue_valid = 1'b1; lvl_sel = 2'd3;
    for (int k = 0; k < 21; k++)
      push(k, k == 20, (k < 16) ? 16'(k) : (k < 20) ? 16'h100 + 16'(k - 16) : 16'h200);
    step();
    issue_valid = 1'b0;
    wait_valid("full_start");
    for (int k = 0; k < 21; k++) begin
      chk("full_consecutive", 32'(o_valid), 32'(1));
      chk("full_idx", 32'(o_idx), 32'(k));
      step();
    end
    chk("full_end_idle", 32'(o_valid), 32'(0));
    chk("full_drained", 32'(exp_q.size()), 32'(0));

    // Backpressure at idx 7 of a lvl0 frame
    issue_valid = 1'b1; lvl_sel = 2'd0;
    for (int k = 0; k < 16; k++) push(k, k == 15, 16'(k));
    step();
    issue_valid = 1'b0;
    cnt = 0;
    while (!(o_valid === 1'b1 && o_idx === 5'd7) && cnt < 100) begin
      step();
      cnt++;
    end
    chk("bp_reach_idx7", 32'(o_idx), 32'(7));
    o_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", 32'(o_valid), 32'(1));
      chk("bp_hold_data", 32'(o_data), 32'(7));
      chk("bp_hold_idx", 32'(o_idx), 32'(7));
      step();
    end
    o_ready = 1'b1;
    wait_drain("bp_drained");
    step();

    // Credit limit: third issue dropped, two frames emitted with a gap
    il3 = 16'h0555; o_ready = 1'b0;
    issue_valid = 1'b1; lvl_sel = 2'd2;
    chk("cr_ready_c0", 32'(issue_ready), 32'(1));
    step();
    chk("cr_ready_c1", 32'(issue_ready), 32'(1));
    step();
    chk("cr_ready_c2", 32'(issue_ready), 32'(0));
    step();
    issue_valid = 1'b0;
    chk("cr_err_drop", 32'(err_drop), 32'(1));
    push(0, 1'b1, 16'h0555);
    push(0, 1'b1, 16'h0555);
    repeat (10) step();
    chk("cr_stalled_valid", 32'(o_valid), 32'(1));
    o_ready = 1'b1;
    step();
    chk("cr_gap", 32'(o_valid), 32'(0));
    step();
    chk("cr_second", 32'(o_valid), 32'(1));
    step();
    chk("cr_after", 32'(o_valid), 32'(0));
    chk("cr_drained", 32'(exp_q.size()), 32'(0));
    repeat (4) step();
    chk("cr_no_third", 32'(o_valid), 32'(0));
    chk("cr_ready_back", 32'(issue_ready), 32'(1));

    // Reset at idx 10 of a lvl3 frame with a second frame queued
    il3 = 16'h200;
    issue_valid = 1'b1; lvl_sel = 2'd3;
    step();
    step();
    issue_valid = 1'b0;
    for (int k = 0; k < 10; k++) push(k, 1'b0, 16'(k));
    cnt = 0;
    while (!(o_valid === 1'b1 && o_idx === 5'd10) && cnt < 100) begin
      step();
      cnt++;
    end
    chk("mr_reach_idx10", 32'(o_idx), 32'(10));
    o_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; o_ready = 1'b1;
    chk("mr_o_valid", 32'(o_valid), 32'(0));
    chk("mr_issue_ready", 32'(issue_ready), 32'(1));
    chk("mr_err_cleared", 32'(err_drop), 32'(0));
    chk("mr_o_idx", 32'(o_idx), 32'(0));
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_valid !== 1'b0) cnt++;
      step();
    end
    chk("mr_no_beats", 32'(cnt), 32'(0));
    chk("mr_sb_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
